// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcode encodings, FSM state type and
// the classification of operations that need the iterative datapath.
package seq_alu_pkg;

    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_XOR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SLL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SRL  = 5'b01001;
    localparam logic [OPW-1:0] OP_SRA  = 5'b01010;
    localparam logic [OPW-1:0] OP_SLT  = 5'b01011;
    localparam logic [OPW-1:0] OP_SLTU = 5'b01100;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01101;
    localparam logic [OPW-1:0] OP_DIVU = 5'b01110;
    localparam logic [OPW-1:0] OP_REMU = 5'b01111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operations served by the iterative MUL/DIV datapath.
    function automatic logic is_multicycle(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath shared by MUL (shift-add) and DIVU/REMU (restoring
// division, MSB first). One iteration per step; done_c flags the step that
// performs the WIDTH-th iteration so the caller can register the result
// from the *_nxt_c values on that same edge.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            load operands (a, b) and mode, clear counter
//   div_mode         1 = divide, 0 = multiply (sampled on start)
//   step             perform one iteration this cycle
//   a, b             operands (multiplicand/multiplier or dividend/divisor)
//   done_c           last iteration happens this cycle
//   acc_nxt_c        next accumulator: product (MUL) or remainder (DIV)
//   shq_nxt_c        next shift register: quotient (DIV)
module seq_alu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div_mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] acc_nxt_c,
    output logic [WIDTH-1:0] shq_nxt_c
);

    localparam int unsigned CW = SHW + 1;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;   // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] shq_q;     // multiplier (MUL) or dividend->quotient (DIV)
    logic [WIDTH-1:0] mcand_nxt;
    logic             div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // One iteration step. For division the partial remainder is kept below
    // the divisor, so WIDTH+1 bits are enough to detect a negative trial.
    // A zero divisor always succeeds: quotient all-ones, remainder = dividend.
    always_comb begin
        shifted   = {acc_q, shq_q[WIDTH-1]};
        trial     = shifted - {1'b0, mcand_q};
        acc_nxt_c = acc_q;
        shq_nxt_c = shq_q;
        mcand_nxt = mcand_q;
        if (div_q) begin
            if (!trial[WIDTH]) begin
                acc_nxt_c = trial[WIDTH-1:0];
                shq_nxt_c = {shq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_c = shifted[WIDTH-1:0];
                shq_nxt_c = {shq_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (shq_q[0]) begin
                acc_nxt_c = acc_q + mcand_q;
            end
            mcand_nxt = mcand_q << 1;
            shq_nxt_c = shq_q >> 1;
        end
        done_c = step && (cnt_q == CW'(WIDTH - 1));
    end

    // Operand/iteration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            shq_q   <= '0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (start) begin
            acc_q   <= '0;
            mcand_q <= div_mode ? b : a;
            shq_q   <= div_mode ? a : b;
            div_q   <= div_mode;
            cnt_q   <= '0;
        end else if (step) begin
            acc_q   <= acc_nxt_c;
            mcand_q <= mcand_nxt;
            shq_q   <= shq_nxt_c;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/shift/compare plus iterative
// MUL, DIVU and REMU. Result and flags are registered and held until the
// consumer accepts them.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   request handshake (A, B, ALUOp captured on accept)
//   A, B                 operands
//   ALUOp                operation code
//   out_valid, out_ready result handshake
//   C                    result
//   Zero                 C == 0
//   Overflow             signed overflow of ADD/SUB
//   DivZero              DIVU/REMU with B == 0
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero
);

    state_t           state_q, state_n;
    logic [OPW-1:0]   op_q, op_n;
    logic             divz_q, divz_n;
    logic [WIDTH-1:0] c_n;
    logic             zero_n, ovf_n, dz_n;
    logic             start_c, step_c, done_c;
    logic [WIDTH-1:0] acc_nxt_c, shq_nxt_c;
    logic [WIDTH-1:0] alu_res_c, sum_c, diff_c;
    logic             alu_ovf_c;
    logic [SHW-1:0]   sh_c;

    // Single-cycle unit, evaluated on the live inputs at acceptance.
    always_comb begin
        sh_c      = B[SHW-1:0];
        sum_c     = A + B;
        diff_c    = A - B;
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = (A[WIDTH-1] == B[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (A[WIDTH-1] != B[WIDTH-1]) && (diff_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res_c = A & B;
            OP_OR:   alu_res_c = A | B;
            OP_XOR:  alu_res_c = A ^ B;
            OP_SLL:  alu_res_c = A << sh_c;
            OP_SRL:  alu_res_c = A >> sh_c;
            OP_SRA:  alu_res_c = $unsigned($signed(A) >>> sh_c);
            OP_SLT:  alu_res_c = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: alu_res_c = WIDTH'(A < B);
            default: alu_res_c = '0;
        endcase
    end

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_c),
        .div_mode  (ALUOp != OP_MUL),
        .step      (step_c),
        .a         (A),
        .b         (B),
        .done_c    (done_c),
        .acc_nxt_c (acc_nxt_c),
        .shq_nxt_c (shq_nxt_c)
    );

    assign step_c = (state_q == BUSY);

    // Next state and next values of the registered result/flags.
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        divz_n  = divz_q;
        c_n     = C;
        zero_n  = Zero;
        ovf_n   = Overflow;
        dz_n    = DivZero;
        start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_n = ALUOp;
                    if (is_multicycle(ALUOp)) begin
                        state_n = BUSY;
                        start_c = 1'b1;
                        divz_n  = (ALUOp != OP_MUL) && (B == '0);
                    end else begin
                        state_n = DONE;
                        c_n     = alu_res_c;
                        zero_n  = (alu_res_c == '0);
                        ovf_n   = alu_ovf_c;
                        dz_n    = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (done_c) begin
                    state_n = DONE;
                    c_n     = (op_q == OP_DIVU) ? shq_nxt_c : acc_nxt_c;
                    zero_n  = (c_n == '0);
                    ovf_n   = 1'b0;
                    dz_n    = divz_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; handshake outputs follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            divz_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            C         <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            DivZero   <= 1'b0;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            divz_q    <= divz_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            C         <= c_n;
            Zero      <= zero_n;
            Overflow  <= ovf_n;
            DivZero   <= dz_n;
        end
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked ALU that replaces the single-cycle add/sub ALU in the datapath. It keeps the existing ADD/SUB opcode encodings and adds logic, shift and compare operations, plus an iterative unsigned multiply and a restoring divide/remainder. The result and flags are registered and presented through a valid/ready output channel. It sits between the decode/operand stage and writeback. Back-pressure comes from writeback, and multi-cycle operations stall issue through `in_ready`.

## Interface
- `WIDTH`, default 32: operand/result width; power of two, ≥ 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived, not overridden).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operands/opcode valid.
- `in_ready` out 1: block can accept a request.
- `A`, `B` in WIDTH: signed operands (treated unsigned where noted).
- `ALUOp` in 5: operation code.
- `out_valid` out 1: result/flags valid.
- `out_ready` in 1: consumer accepts result.
- `C` out WIDTH: result.
- `Zero` out 1: C == 0.
- `Overflow` out 1: signed overflow (ADD/SUB only, else 0).
- `DivZero` out 1: DIVU/REMU with B == 0.

## Operation
- Opcodes:
  - ADD 00011, SUB 00100, AND 00101, OR 00110, XOR 00111.
  - SLL 01000, SRL 01001, SRA 01010: shift amount is `B[SHW-1:0]`.
  - SLT 01011 (signed), SLTU 01100 (unsigned).
  - MUL 01101: low WIDTH bits of the product.
  - DIVU 01110, REMU 01111.
  - Any other code: C = 0, Zero = 1, other flags 0, single-cycle.
- Requests are accepted only on `in_valid && in_ready`. A, B and ALUOp are captured at acceptance. Input changes afterwards are ignored.
- FSM states:
  - IDLE: `in_ready` = 1. On accept, go to DONE for single-cycle ops, or to BUSY for MUL/DIVU/REMU.
  - BUSY: `in_ready` = 0. One iteration per cycle. An iteration counter (SHW+1 bits) runs 0..WIDTH-1. After the WIDTH-th iteration, go to DONE.
  - DONE: `out_valid` = 1 and C/flags are held stable. On `out_ready`, go to IDLE. With `out_ready` low, the block stays in DONE indefinitely.
- MUL: shift-add. Each cycle, if the multiplier LSB is 1, add the multiplicand. Shift the multiplicand left and the multiplier right.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first. With B == 0:
  - Quotient is all-ones; remainder is A.
  - DivZero = 1.
  - The full WIDTH cycles are still taken, so latency does not depend on data.
- Overflow:
  - ADD: operand signs are equal and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
- Zero is computed from the final C value.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - State goes to IDLE.
  - `out_valid`, `C`, `Zero`, `Overflow` and `DivZero` all go to 0.
  - `in_ready` = 0 while `rst_n` is low, and 1 from the first cycle after release.
- Single-cycle op accepted at edge k: `out_valid` = 1 after edge k.
- Multi-cycle op accepted at edge k: `out_valid` = 1 after edge k+WIDTH.
- Handshake completes at the first edge with `out_valid && out_ready`. `in_ready` returns to 1 after that edge.
- Best-case throughput is one single-cycle op every 2 cycles. `in_ready` is never 1 in DONE.
- Reset asserted in BUSY or DONE aborts the operation. The partial result is discarded and no `out_valid` pulse follows.
- `in_valid` asserted while `in_ready` = 0 has no effect. The requester must hold `in_valid` until acceptance.

## Structure
- Package `seq_alu_pkg` holds:
  - The opcode localparams `OP_ADD` … `OP_REMU`.
  - The FSM state typedef (IDLE, BUSY, DONE).
  - A helper function `is_multicycle(op)`.
- Sub-module `seq_alu_iter` holds the shared MUL/DIV iteration datapath: accumulator, shift registers, counter and done pulse. The top level keeps the FSM, the single-cycle combinational unit and the output registers.

## Test plan
- Reset: hold `rst_n` low for 3 cycles mid-MUL, then release.
  - Required: `out_valid` = 0 and C = 0.
  - Required: `in_ready` = 1 one cycle after release; no stale result appears.
- ADD overflow (WIDTH = 32): A = 0x7FFFFFFF, B = 1.
  - Required: C = 0x80000000, Overflow = 1, Zero = 0, with `out_valid` the cycle after accept.
- SUB to zero: A = B = 0x1234.
  - Required: C = 0, Zero = 1, Overflow = 0.
- SRA: A = 0x80000000, B = 4.
  - Required: C = 0xF8000000.
- SLT and SLTU: A = -1, B = 1.
  - Required: SLT gives C = 1; SLTU gives C = 0.
- MUL with back-pressure: A = 12345, B = 6789, `out_ready` held low 5 cycles after `out_valid`.
  - Required: C = 83810205, `out_valid` exactly 32 cycles after accept, and C held stable while stalled.
- DIVU/REMU: A = 100, B = 7.
  - Required: DIVU gives 14; REMU gives 2.
  - With B = 0: C = 0xFFFFFFFF for DIVU and C = 100 for REMU, DivZero = 1.
- Illegal opcode 11111.
  - Required: C = 0, Zero = 1, single-cycle latency.
